// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding and oversampling ratio for the
// transmitter and receiver.
package uart_pkg;
  localparam int OVERSAMPLE = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    START = ST_START,
    DATA  = ST_DATA,
    STOP  = ST_STOP
  } state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/uart_tx_if.sv
// Byte/strobe side of the UART transmitter plus the baud tick and serial line.
interface uart_tx_if #(parameter int NB_DATA = 8);
  logic               i_s_tick;
  logic               i_tx_start;
  logic [NB_DATA-1:0] i_tx_data;
  logic               o_tx;
  logic               o_tx_done_tick;
  logic               o_tx_busy;

  modport master (output i_s_tick, i_tx_start, i_tx_data,
                  input  o_tx, o_tx_done_tick, o_tx_busy);
  modport slave  (input  i_s_tick, i_tx_start, i_tx_data,
                  output o_tx, o_tx_done_tick, o_tx_busy);
endinterface

// File: rtl/uart_tx.sv
// UART serializer: start bit, NB_DATA data bits LSB first, STOP_TICKS-long
// stop interval, timed by the 16x oversampling baud tick.
module uart_tx
  import uart_pkg::*;
#(
  parameter int NB_DATA    = 8,
  parameter int STOP_TICKS = 16
) (
  input  logic      i_clk,
  input  logic      i_reset,
  uart_tx_if.slave  bus
);
  localparam int TW = $clog2(max2(OVERSAMPLE, STOP_TICKS));
  localparam int BW = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] STOP_LAST = TW'(STOP_TICKS - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(NB_DATA - 1);

  state_e             state_q, state_d;
  logic [TW-1:0]      tick_q, tick_d;
  logic [BW-1:0]      bit_q, bit_d;
  logic [NB_DATA-1:0] sr_q, sr_d;
  logic               tx_q, tx_d;
  logic               done_q, done_d;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (bus.i_tx_start) begin
        sr_d    = bus.i_tx_data;
        tick_d  = '0;
        state_d = START;
      end
      START: if (bus.i_s_tick) begin
        if (tick_q == TICK_LAST) begin
          tick_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else tick_d = tick_q + 1'b1;
      end
      DATA: if (bus.i_s_tick) begin
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          sr_d   = sr_q >> 1;
          if (bit_q == BIT_LAST) state_d = STOP;
          else                   bit_d   = bit_q + 1'b1;
        end else tick_d = tick_q + 1'b1;
      end
      STOP: if (bus.i_s_tick) begin
        if (tick_q == STOP_LAST) begin
          tick_d  = '0;
          state_d = IDLE;
          done_d  = 1'b1;
        end else tick_d = tick_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Line level follows the next state so o_tx can be a plain register.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = sr_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  assign bus.o_tx           = tx_q;
  assign bus.o_tx_done_tick = done_q;
  assign bus.o_tx_busy      = (state_q != IDLE);
endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: a 1-stop and a 2-stop instance share stimulus;
// a bench-side mid-bit sampler decodes the line of the selected instance.
module tb_uart_tx;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s_tick = 1'b1;
  logic       start = 1'b0;
  logic [7:0] data = 8'h00;
  logic       sel = 1'b0;
  int         per = 1;
  int         tcnt = 0;
  int         cyc = 0;
  int         done_cnt = 0;
  int         rise_cyc = 0;
  logic       tx_prev = 1'b1;
  int         errors = 0;
  int         checks = 0;

  uart_tx_if #(.NB_DATA(8)) if16();
  uart_tx_if #(.NB_DATA(8)) if32();

  assign if16.i_s_tick = s_tick;  assign if32.i_s_tick = s_tick;
  assign if16.i_tx_start = start; assign if32.i_tx_start = start;
  assign if16.i_tx_data = data;   assign if32.i_tx_data = data;

  uart_tx #(.NB_DATA(8), .STOP_TICKS(16)) dut16 (.i_clk(clk), .i_reset(rst), .bus(if16));
  uart_tx #(.NB_DATA(8), .STOP_TICKS(32)) dut32 (.i_clk(clk), .i_reset(rst), .bus(if32));

  wire tx_m   = sel ? if32.o_tx           : if16.o_tx;
  wire done_m = sel ? if32.o_tx_done_tick : if16.o_tx_done_tick;
  wire busy_m = sel ? if32.o_tx_busy      : if16.o_tx_busy;

  always #5 clk = ~clk;

  // Tick for the next edge is set 2ns after each edge.
  always @(posedge clk) begin
    #2;
    tcnt   = (tcnt + 1 >= per) ? 0 : tcnt + 1;
    s_tick = (tcnt == 0);
  end

  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (done_m === 1'b1) done_cnt = done_cnt + 1;
    if (tx_m === 1'b1 && tx_prev === 1'b0) rise_cyc = cyc;
    tx_prev = tx_m;
  end

  task automatic step();
    @(posedge clk); #3;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((if16.o_tx_busy !== 1'b0 || if32.o_tx_busy !== 1'b0) && t < 5000) begin
      step(); t++;
    end
    if (t >= 5000) chk("idle timeout", 1, 0);
  endtask

  // Start is raised so that it coincides with a baud tick at the edge.
  task automatic send(input logic [7:0] d);
    int t = 0;
    while (s_tick !== 1'b1 && t < 100) begin step(); t++; end
    data = d; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic rx_frame(input logic [7:0] d, input int p, input int stop,
                          input bit b2b, input logic [7:0] nd,
                          output int fall_o, output int done_o);
    int t, f, dc0;
    fall_o = -1; done_o = -1;
    t = 0;
    while (tx_m !== 1'b0 && t < 4000) begin step(); t++; end
    if (t >= 4000) begin chk("fall timeout", 1, 0); return; end
    f = cyc; fall_o = f; dc0 = done_cnt;
    repeat (8*p) step();
    chk("start bit", int'(tx_m), 0);
    for (int i = 0; i < 8; i++) begin
      repeat (16*p) step();
      chk($sformatf("data %02h bit %0d", d, i), int'(tx_m), int'(d[i]));
    end
    repeat (16*p) step();
    chk("stop bit", int'(tx_m), 1);
    t = 0;
    while (done_m !== 1'b1 && t < 4000) begin step(); t++; end
    chk("done timeout", int'(t >= 4000), 0);
    done_o = cyc;
    chk("frame clocks", cyc - f, (144 + stop) * p);
    chk("busy in done cycle", int'(busy_m), 0);
    if (b2b) begin data = nd; start = 1'b1; end
    step();
    start = 1'b0;
    chk("done one cycle", int'(done_m), 0);
    chk("done count", done_cnt - dc0, 1);
    if (d == 8'h00) chk("low run clocks", rise_cyc - f, 144 * p);
  endtask

  typedef struct {
    logic [7:0] d;
    int         p;
    logic       s32;
    int         stop;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int f, dn, f2, dn2, dc;
    vecs[0] = '{d: 8'hA5, p: 1, s32: 1'b0, stop: 16};
    vecs[1] = '{d: 8'h00, p: 5, s32: 1'b1, stop: 32};
    vecs[2] = '{d: 8'h5A, p: 3, s32: 1'b0, stop: 16};
    vecs[3] = '{d: 8'hFF, p: 1, s32: 1'b1, stop: 32};

    rst = 1'b1;
    repeat (3) step();
    chk("reset tx16", int'(if16.o_tx), 1);
    chk("reset busy16", int'(if16.o_tx_busy), 0);
    chk("reset done16", int'(if16.o_tx_done_tick), 0);
    chk("reset tx32", int'(if32.o_tx), 1);
    chk("reset busy32", int'(if32.o_tx_busy), 0);
    rst = 1'b0;
    step();
    chk("idle tx", int'(if16.o_tx), 1);

    for (int v = 0; v < 4; v++) begin
      wait_idle();
      per = vecs[v].p; sel = vecs[v].s32;
      repeat (2) step();
      send(vecs[v].d);
      chk("busy after start", int'(busy_m), 1);
      rx_frame(vecs[v].d, vecs[v].p, vecs[v].stop, 1'b0, 8'h00, f, dn);
    end

    // Start and data changes while busy are ignored.
    wait_idle();
    per = 1; sel = 1'b0;
    step();
    send(8'h3C);
    dc = done_cnt;
    fork
      rx_frame(8'h3C, 1, 16, 1'b0, 8'h00, f, dn);
      begin
        repeat (64) step();
        data = 8'hFF; start = 1'b1;
        step();
        start = 1'b0;
      end
    join
    repeat (40) step();
    chk("no queued frame", int'(if16.o_tx_busy), 0);
    chk("single done busy test", done_cnt - dc, 1);

    // Back-to-back: second start raised in the done cycle.
    wait_idle();
    step();
    send(8'h7E);
    rx_frame(8'h7E, 1, 16, 1'b1, 8'h81, f, dn);
    rx_frame(8'h81, 1, 16, 1'b0, 8'h00, f2, dn2);
    chk("b2b gap", f2 - dn, 1);

    // Reset in the middle of data bit 4.
    wait_idle();
    step();
    send(8'h55);
    chk("55 start", int'(if16.o_tx), 0);
    dc = done_cnt;
    repeat (16*5 + 8 - 1) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort tx", int'(if16.o_tx), 1);
    chk("abort busy", int'(if16.o_tx_busy), 0);
    chk("abort done", int'(if16.o_tx_done_tick), 0);
    repeat (200) step();
    chk("abort no done", done_cnt - dc, 0);
    send(8'h55);
    rx_frame(8'h55, 1, 16, 1'b0, 8'h00, f, dn);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_tx.md
# uart_tx

UART serializer that is the transmit half of the TP2 UART, the counterpart of the receiver. It takes one parallel byte on a start strobe and drives it out on the serial line as one start bit, NB_DATA data bits (LSB first) and a stop interval. Bit timing comes from the shared 16× oversampling baud tick. It sits between the baud-rate generator and the interface/ALU control logic, with the same frame format the receiver expects.

## Interface
- NB_DATA, 8, data bits per frame.
- STOP_TICKS, 16, baud ticks in the stop interval (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- i_clk  input  1  system clock; all logic on the rising edge.
- i_reset  input  1  reset, synchronous to i_clk, active-high.
- i_s_tick  input  1  baud tick, one-cycle pulse at 16× the bit rate.
- i_tx_start  input  1  request to send; sampled only in IDLE.
- i_tx_data  input  NB_DATA  byte to send; captured in the cycle i_tx_start is accepted.
- o_tx  output  1  serial line, idle high; registered.
- o_tx_done_tick  output  1  one-cycle pulse at end of frame; registered.
- o_tx_busy  output  1  high whenever state ≠ IDLE.

## Operation
- States: IDLE, START, DATA, STOP.
- Registers: state, tick counter, bit counter, shift register (NB_DATA) and tx register.
  - Tick counter width is clog2(max(16, STOP_TICKS)).
  - Bit counter width is clog2(NB_DATA).
- Reset values:
  - state = IDLE, counters = 0, shift register = 0.
  - o_tx = 1, o_tx_done_tick = 0, o_tx_busy = 0.
- IDLE: o_tx = 1.
  - If i_tx_start = 1: load shift register with i_tx_data, clear the tick counter and go to START.
  - i_s_tick is not required for this transition.
- START: o_tx = 0.
  - Each i_s_tick increments the tick counter.
  - On the tick that arrives with the counter at 15: clear both counters and go to DATA.
- DATA: o_tx = shift register[0].
  - On the tick that arrives with the counter at 15: clear the tick counter and shift the register right by one.
  - If the bit counter = NB_DATA-1, go to STOP; otherwise increment the bit counter.
- STOP: o_tx = 1.
  - On the tick that arrives with the counter at STOP_TICKS-1: clear the tick counter, go to IDLE and pulse o_tx_done_tick.
- Clock cycles without i_s_tick leave all counters and the state unchanged (except the IDLE start acceptance).
- i_tx_start outside IDLE is ignored. It is not queued, and i_tx_data changes do not affect the frame in flight.
- Illegal state encodings go to IDLE with o_tx = 1.
- Reset asserted mid-frame aborts the frame. The next cycle shows the reset values, with o_tx = 1 and no done pulse.

## Timing
- o_tx is driven from a register. It reflects the new state one cycle after the transition decision.
  - i_tx_start accepted at cycle N → o_tx = 0 and o_tx_busy = 1 from cycle N+1.
- Each start and data bit lasts exactly 16 i_s_tick periods. The stop interval lasts STOP_TICKS periods.
- Frame length: 16·(1+NB_DATA)+STOP_TICKS ticks (160 for the defaults).
- o_tx_done_tick is high for exactly one cycle: the cycle after the final stop tick. In that same cycle, o_tx_busy = 0.
- Back-to-back: i_tx_start asserted during the o_tx_done_tick cycle is accepted. The next start bit begins one cycle later with no extra idle ticks.
- An i_tx_start pulse coincident with an i_s_tick in IDLE behaves identically to one without the tick.

## Structure
- Shared package uart_pkg holds:
  - state encoding localparams (2 bits; IDLE=0, START=1, DATA=2, STOP=3);
  - the oversampling constant OVERSAMPLE = 16.
- The receiver uses the same encoding from this package.
- Single flat module: a state register block plus a next-state combinational block. No sub-module; the baud generator stays external.

## Test plan
- Reset: hold i_reset 3 cycles → o_tx = 1, o_tx_busy = 0, o_tx_done_tick = 0.
- Single frame 8'hA5, i_s_tick every clock:
  - line samples at mid-bit read 0, then 1,0,1,0,0,1,0,1, then 1;
  - o_tx_done_tick fires once, 160 ticks after o_tx falls.
- Start ignored while busy: send 8'h3C, pulse i_tx_start with 8'hFF in the middle of the data phase → only 8'h3C is transmitted, with one done pulse.
- Back-to-back: re-assert i_tx_start with 8'h81 in the done cycle → second start bit follows the first stop interval with zero gap; both bytes decode correctly through a loopback to the UART receiver.
- Sparse ticks and STOP_TICKS = 32: i_s_tick every 5 clocks, send 8'h00 → each bit lasts 80 clocks and the stop interval 160 clocks.
- Reset mid-frame: assert i_reset during data bit 4 of 8'h55 → o_tx = 1 the next cycle, no done pulse; a following 8'h55 frame completes normally.
